// File: rtl/gx4000_joy_conditioner.sv
// Joystick front-end for the GX4000 I/O block: synchronise, debounce, SOCD-clean,
// autofire and player swap of the two raw joystick buses.
module gx4000_joy_conditioner #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [19:0] AUTOFIRE_DIV    = 20'd400000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [6:0] joy1_raw,
  input  logic [6:0] joy2_raw,
  input  logic       joy_swap,
  input  logic [1:0] autofire_en,
  output logic [6:0] joy1,
  output logic [6:0] joy2,
  output logic       changed
);

  logic [13:0] sync_a;
  logic [13:0] sync_b;
  logic [13:0] stable;
  logic [19:0] af_cnt;
  logic        af_phase;
  logic        af_active;
  logic        swap_q;
  logic [6:0]  p1;
  logic [6:0]  p2;
  logic [6:0]  next1;
  logic [6:0]  next2;

  // Opposing directions pressed together cancel to neutral; fire bits pass through.
  function automatic logic [6:0] socd(input logic [6:0] b);
    logic [6:0] r;
    r = b;
    if (b[0] && b[1]) r[1:0] = 2'b00;
    if (b[2] && b[3]) r[3:2] = 2'b00;
    return r;
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {joy2_raw, joy1_raw};
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < 14; i++) begin : g_debounce
    logic [15:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        cnt       <= '0;
        stable[i] <= 1'b0;
      end else if (sync_b[i] == stable[i]) begin
        cnt <= '0;
      end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
        cnt       <= '0;
        stable[i] <= sync_b[i];
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign af_active = (autofire_en[0] & stable[4]) | (autofire_en[1] & stable[11]);

  // Idle state keeps phase high so a fresh press fires on its very first output cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (!af_active) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) swap_q <= 1'b0;
    else       swap_q <= joy_swap;
  end

  always_comb begin
    p1    = socd(stable[6:0]);
    p2    = socd(stable[13:7]);
    p1[4] = stable[4]  & (~autofire_en[0] | af_phase);
    p2[4] = stable[11] & (~autofire_en[1] | af_phase);
    next1 = swap_q ? p2 : p1;
    next2 = swap_q ? p1 : p2;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy1    <= '0;
      joy2    <= '0;
      changed <= 1'b0;
    end else begin
      joy1    <= next1;
      joy2    <= next2;
      changed <= ({next1, next2} != {joy1, joy2});
    end
  end

endmodule
